// File: rtl/alu_op_sequencer.sv
// Valid/ready sequencer that registers operands into a combinational ALU and returns its outputs one cycle later.
// Optional sticky overflow trap that stalls new requests is enabled with `define ALU_OVF_TRAP_EN.
module alu_op_sequencer #(
  parameter int n     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [n-1:0]     req_a,
  input  logic [n-1:0]     req_b,
  output logic [n-1:0]     alu_A,
  output logic [n-1:0]     alu_B,
  output logic [2:0]       alu_ALUctr,
  input  logic [n-1:0]     alu_Result,
  input  logic             alu_Zero,
  input  logic             alu_Overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [n-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_trap,
  input  logic             trap_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   trap_block;
  logic   accept;
  logic   capture;
  logic   rsp_fire;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !trap_block;
        if (req_valid && !trap_block) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = (state == IDLE) && req_valid && !trap_block;
  assign capture  = (state == EXEC);
  assign rsp_fire = (state == RESP) && rsp_ready;

  // ALU inputs only move on an accepted request, so the ALU never sees intermediate values.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_A      <= '0;
      alu_B      <= '0;
      alu_ALUctr <= 3'b000;
    end else if (accept) begin
      alu_A      <= req_a;
      alu_B      <= req_b;
      alu_ALUctr <= req_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (capture) begin
      rsp_result   <= alu_Result;
      rsp_zero     <= alu_Zero;
      rsp_overflow <= alu_Overflow;
    end
  end

  // Counts handed-off responses only; an op dropped by reset never reaches RESP handshake.
  always_ff @(posedge clk) begin
    if (rst)           op_count <= '0;
    else if (rsp_fire) op_count <= op_count + 1'b1;
  end

`ifdef ALU_OVF_TRAP_EN
  logic trap_q;

  // A new overflow capture takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                         trap_q <= 1'b0;
    else if (capture && alu_Overflow) trap_q <= 1'b1;
    else if (trap_clr)               trap_q <= 1'b0;
  end

  assign ovf_trap   = trap_q;
  assign trap_block = trap_q;
`else
  logic unused_trap_clr;

  assign unused_trap_clr = trap_clr;
  assign ovf_trap        = 1'b0;
  assign trap_block      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with an XOR/compare ALU stub and a transaction-level model.
// Trap behaviour is checked when ALU_OVF_TRAP_EN is defined for both bench and RTL.
module tb_alu_op_sequencer;

  localparam int n     = 32;
  localparam int CNT_W = 4;
`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [n-1:0]     req_a;
  logic [n-1:0]     req_b;
  logic [n-1:0]     alu_A;
  logic [n-1:0]     alu_B;
  logic [2:0]       alu_ALUctr;
  logic [n-1:0]     alu_Result;
  logic             alu_Zero;
  logic             alu_Overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [n-1:0]     rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic [CNT_W-1:0] op_count;
  logic             ovf_trap;
  logic             trap_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  bit exp_trap  = 1'b0;

  always #5 clk = ~clk;

  // ALU stub
  assign alu_Result   = alu_A ^ alu_B;
  assign alu_Zero     = (alu_A == alu_B);
  assign alu_Overflow = alu_A[n-1] & alu_B[n-1];

  alu_op_sequencer #(.n(n), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_ALUctr   (alu_ALUctr),
    .alu_Result   (alu_Result),
    .alu_Zero     (alu_Zero),
    .alu_Overflow (alu_Overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .op_count     (op_count),
    .ovf_trap     (ovf_trap),
    .trap_clr     (trap_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: accept, capture, optional back-pressure, handshake, trap clear.
  task automatic do_op(input logic [n-1:0] a, input logic [n-1:0] b, input logic [2:0] op,
                       input int stall, input bit clr_at_cap);
    logic [n-1:0] e_res;
    bit           e_zero;
    bit           e_ovf;
    e_res  = a ^ b;
    e_zero = (a == b);
    e_ovf  = a[n-1] & b[n-1];

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    rsp_ready = (stall == 0);

    @(posedge clk); #1;
    check("exec_alu_A", alu_A, a);
    check("exec_alu_B", alu_B, b);
    check("exec_alu_ALUctr", alu_ALUctr, op);
    check("exec_req_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    // A fresh request held during EXEC/RESP must be ignored.
    req_a    = $urandom;
    req_b    = $urandom;
    req_op   = 3'($urandom);
    trap_clr = clr_at_cap;

    @(posedge clk); #1;
    trap_clr = 1'b0;
    if (TRAP_EN) begin
      if (e_ovf) exp_trap = 1'b1;
      else if (clr_at_cap) exp_trap = 1'b0;
    end
    check("resp_valid", rsp_valid, 1);
    check("resp_result", rsp_result, e_res);
    check("resp_zero", rsp_zero, e_zero);
    check("resp_overflow", rsp_overflow, e_ovf);
    check("resp_ovf_trap", ovf_trap, exp_trap);
    check("resp_alu_A_held", alu_A, a);
    check("resp_op_count", op_count, exp_count);

    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, e_res);
      check("bp_zero", rsp_zero, e_zero);
      check("bp_overflow", rsp_overflow, e_ovf);
      check("bp_req_ready", req_ready, 0);
      check("bp_op_count", op_count, exp_count);
    end
    rsp_ready = 1'b1;

    @(posedge clk); #1;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("hs_rsp_valid", rsp_valid, 0);
    check("hs_op_count", op_count, exp_count);
    check("hs_req_ready", req_ready, !exp_trap);
    check("hs_ovf_trap", ovf_trap, exp_trap);

    if (exp_trap) begin
      trap_clr = 1'b1;
      @(posedge clk); #1;
      trap_clr = 1'b0;
      exp_trap = 1'b0;
      check("clr_ovf_trap", ovf_trap, 0);
      check("clr_req_ready", req_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [n-1:0] ra;
    logic [n-1:0] rb;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; trap_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_A", alu_A, 0);
    check("rst_alu_ALUctr", alu_ALUctr, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_op_count", op_count, 0);
    check("rst_ovf_trap", ovf_trap, 0);

    // Reset during EXEC drops the op.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h0F0F_0F0F; req_op = 3'b101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("drop_alu_A", alu_A, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("drop_rsp_valid", rsp_valid, 0);
    check("drop_alu_A_cleared", alu_A, 0);
    check("drop_op_count", op_count, exp_count);
    check("drop_req_ready", req_ready, 1);
    repeat (2) @(posedge clk); #1;
    check("drop_no_rsp", rsp_valid, 0);

    do_op(32'h0000_00F0, 32'h0000_000F, 3'b010, 0, 1'b0);
    check("t1_op_count", op_count, 1);
    do_op(32'h1234_5678, 32'h1234_5678, 3'b110, 0, 1'b0);
    do_op(32'hA5A5_0001, 32'h5A5A_1000, 3'b001, 10, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 3'b011, 2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : n'($urandom);
      do_op(ra, rb, 3'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
